// File: rtl/spi_flash_loader_if.sv
// spi_flash_loader_if: SRAM port bundle (chip select, output enable, write enable, address, write data).
//   master: drives the SRAM pins (the loader's ext side)
//   slave : receives strobes from the Atom core (the loader's atom side)
interface spi_flash_loader_if;
    logic        cs_b;
    logic        oe_b;
    logic        we_b;
    logic [17:0] a;
    logic [7:0]  din;
    modport master (output cs_b, oe_b, we_b, a, din);
    modport slave  (input  cs_b, oe_b, we_b, a, din);
endinterface

// File: rtl/spi_flash_loader.sv
// spi_flash_loader: SPI-master boot loader copying a flash image (0x03 READ, mode 0) into external SRAM.
//   clk, reset_b   : clock, asynchronous active-low reset
//   booting        : high until the whole image has been written
//   progress       : one-cycle pulse per byte written
//   SCK/SSEL/MOSI  : SPI master outputs (SCK idles low, SSEL active low)
//   MISO           : flash read data
//   atom (slave)   : Atom core SRAM strobes/address/data
//   ext (master)   : SRAM pins; owned by the loader while booting, pass-through afterwards
//   Optional macro FLASH_WAKEUP_EN: send 0xAB and wait 4096 clk before the READ.
module spi_flash_loader #(
    parameter logic [17:0] BOOT_START_ADDR  = 18'h0C000,
    parameter logic [17:0] BOOT_END_ADDR    = 18'h0FFFF,
    parameter logic [23:0] FLASH_START_ADDR = 24'h000000,
    parameter int          CLK_DIV          = 2
) (
    input  logic clk,
    input  logic reset_b,
    output logic booting,
    output logic progress,
    output logic SCK,
    output logic SSEL,
    output logic MOSI,
    input  logic MISO,
    spi_flash_loader_if.slave  atom,
    spi_flash_loader_if.master ext
);
    typedef enum logic [3:0] {
        ST_WAKE, ST_GAP, ST_START, ST_CMD, ST_READ,
        ST_WR1, ST_WR2, ST_WR3, ST_WR4, ST_DONE
    } state_t;
`ifdef FLASH_WAKEUP_EN
    localparam state_t ST_INIT = ST_WAKE;
`else
    localparam state_t ST_INIT = ST_START;
`endif
    state_t      state;
    logic [30:0] sh;
    logic [7:0]  rx;
    logic [7:0]  data;
    logic [17:0] addr;
    logic        we_b;
    logic [15:0] cnt;
    logic [4:0]  bits;
    logic        wake;
    logic        tick;
    // cnt times each SCK half-period; it doubles as the post-wakeup gap timer
    assign tick = cnt == 16'(CLK_DIV - 1);
    assign ext.cs_b = booting ? 1'b0 : atom.cs_b;
    assign ext.oe_b = booting ? 1'b1 : atom.oe_b;
    assign ext.we_b = booting ? we_b : atom.we_b;
    assign ext.a    = booting ? addr : atom.a;
    assign ext.din  = booting ? data : atom.din;
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state    <= ST_INIT;
            booting  <= 1'b1;
            progress <= 1'b0;
            SSEL     <= 1'b1;
            SCK      <= 1'b0;
            MOSI     <= 1'b0;
            we_b     <= 1'b1;
            addr     <= BOOT_START_ADDR;
            data     <= 8'h00;
            sh       <= '0;
            rx       <= 8'h00;
            cnt      <= '0;
            bits     <= '0;
            wake     <= 1'b0;
        end else begin
            progress <= 1'b0;
            case (state)
                ST_WAKE: begin
                    SSEL  <= 1'b0;
                    MOSI  <= 1'b1;
                    sh    <= {7'b0101011, 24'h0};
                    wake  <= 1'b1;
                    cnt   <= '0;
                    state <= ST_CMD;
                end
                ST_GAP: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == 16'd4095) state <= ST_START;
                end
                ST_START: begin
                    SSEL  <= 1'b0;
                    MOSI  <= 1'b0;
                    sh    <= {7'h03, FLASH_START_ADDR};
                    wake  <= 1'b0;
                    cnt   <= '0;
                    state <= ST_CMD;
                end
                ST_CMD: begin
                    cnt <= tick ? 16'd0 : cnt + 16'd1;
                    // MOSI advances on the falling SCK edge so it is stable across the rise
                    if (tick) begin
                        SCK <= ~SCK;
                        if (SCK) begin
                            MOSI <= sh[30];
                            sh   <= {sh[29:0], 1'b0};
                            bits <= (bits == (wake ? 5'd7 : 5'd31)) ? 5'd0 : bits + 5'd1;
                            if (bits == (wake ? 5'd7 : 5'd31)) begin
                                state <= wake ? ST_GAP : ST_READ;
                                if (wake) SSEL <= 1'b1;
                            end
                        end
                    end
                end
                ST_READ: begin
                    cnt <= tick ? 16'd0 : cnt + 16'd1;
                    if (tick) begin
                        SCK <= ~SCK;
                        if (!SCK) rx <= {rx[6:0], MISO};
                        else begin
                            bits <= (bits == 5'd7) ? 5'd0 : bits + 5'd1;
                            if (bits == 5'd7) begin
                                data  <= rx;
                                state <= ST_WR1;
                            end
                        end
                    end
                end
                ST_WR1: begin
                    we_b     <= 1'b0;
                    progress <= 1'b1;
                    state    <= ST_WR2;
                end
                ST_WR2: state <= ST_WR3;
                ST_WR3: begin
                    we_b  <= 1'b1;
                    state <= ST_WR4;
                end
                ST_WR4: begin
                    if (addr == BOOT_END_ADDR) begin
                        SSEL  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        addr  <= addr + 18'd1;
                        state <= ST_READ;
                    end
                end
                ST_DONE: booting <= 1'b0;
                default: state <= ST_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_loader.sv
// tb_spi_flash_loader: three loader instances (different parameters) against a behavioural SPI flash and SRAM model.
module tb_spi_flash_loader;
    localparam logic [2:0][17:0] BS = {18'h3FFF0, 18'h00100, 18'h0C000};
    localparam logic [2:0][17:0] BE = {18'h3FFFF, 18'h00100, 18'h0C0FF};
    localparam logic [2:0][23:0] FA = {24'hFFFFF8, 24'h123456, 24'h000000};
    localparam logic [2:0][3:0]  CD = {4'd4, 4'd1, 4'd2};

    logic clk = 0;
    logic reset_b = 0;
    logic reset_b0 = 0;
    int   cyc = 0;
    logic a_cs = 1, a_oe = 1, a_we = 1;
    logic [17:0] a_a = '0;
    logic [7:0]  a_d = '0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int CDV = int'(CD[g]);
        logic booting, progress, sck, ssel, mosi, rbl;
        logic miso = 1'b0;
        spi_flash_loader_if atom_if();
        spi_flash_loader_if ext_if();
        assign atom_if.cs_b = a_cs;
        assign atom_if.oe_b = a_oe;
        assign atom_if.we_b = a_we;
        assign atom_if.a    = a_a;
        assign atom_if.din  = a_d;
        assign rbl = (g == 0) ? reset_b0 : reset_b;

        spi_flash_loader #(
            .BOOT_START_ADDR(BS[g]), .BOOT_END_ADDR(BE[g]),
            .FLASH_START_ADDR(FA[g]), .CLK_DIV(CDV)
        ) dut (
            .clk(clk), .reset_b(rbl), .booting(booting), .progress(progress),
            .SCK(sck), .SSEL(ssel), .MOSI(mosi), .MISO(miso),
            .atom(atom_if), .ext(ext_if)
        );

        // flash: records the first 32 bits of each transaction; streams data[a] = a[7:0]^0x5A
        int nbits = 0;
        int rise_cyc = -1;
        logic [31:0] head = '0;
        logic [31:0] heads[$];
        int lens[$];
        int gaps[$];
        always @(posedge sck or posedge ssel or negedge ssel) begin
            if (ssel) begin
                if (nbits > 0) begin
                    heads.push_back(head);
                    lens.push_back(nbits);
                end
                nbits = 0;
                head = '0;
                rise_cyc = cyc;
            end else if (!sck) begin
                if (rise_cyc >= 0) gaps.push_back(cyc - rise_cyc);
                nbits = 0;
                head = '0;
            end else begin
                if (nbits < 32) head = {head[30:0], mosi};
                nbits++;
            end
        end
        always @(negedge sck) begin
            int b;
            logic [23:0] fa;
            logic [7:0] v;
            if (nbits >= 32) begin
                b = nbits - 32;
                fa = head[23:0] + 24'(b / 8);
                v = fa[7:0] ^ 8'h5A;
                miso = v[7 - b % 8];
            end
        end

        // SRAM model and protocol monitor
        logic [7:0] mem [logic [17:0]];
        int n_prog = 0, n_rise = 0, n_bfall = 0, n_wr = 0;
        int bad_mux = 0, bad_we = 0, bad_spi = 0, bad_ssel = 0;
        int hi = 0, lo = 0, wl = 0;
        logic p_sck = 0, p_mosi = 0, p_boot = 1, p_ssel = 1, p_we = 1;
        logic [17:0] p_a = '0;
        logic [7:0]  p_d = '0;
        always @(negedge clk) begin
            if (!rbl) begin
                hi = 0;
                lo = 0;
                wl = 0;
            end else begin
                if (progress) n_prog++;
                if (ssel) lo = 0;
                if (sck && !p_sck) begin
                    n_rise++;
                    if (lo != CDV && lo != CDV + 4) bad_spi++;
                    lo = 0;
                end
                if (!sck && p_sck) begin
                    if (hi != CDV) bad_spi++;
                    hi = 0;
                end
                if (sck) hi++;
                else if (!ssel) lo++;
                if (sck && mosi !== p_mosi) bad_spi++;
                if (p_boot && !booting) begin
                    n_bfall++;
                    if (!p_ssel || !ssel) bad_ssel++;
                end
                if (booting) begin
                    if (ext_if.cs_b !== 1'b0 || ext_if.oe_b !== 1'b1) bad_mux++;
                    if (!ext_if.we_b) begin
                        if (p_we && (ext_if.a !== p_a || ext_if.din !== p_d)) bad_we++;
                        wl++;
                    end else if (wl > 0) begin
                        if (wl != 2 || ext_if.a !== p_a || ext_if.din !== p_d) bad_we++;
                        mem[ext_if.a] = ext_if.din;
                        n_wr++;
                        wl = 0;
                    end
                end else if ({ext_if.cs_b, ext_if.oe_b, ext_if.we_b, ext_if.a, ext_if.din} !==
                             {a_cs, a_oe, a_we, a_a, a_d}) bad_mux++;
            end
            p_sck = sck;
            p_mosi = mosi;
            p_boot = booting;
            p_ssel = ssel;
            p_we = ext_if.we_b;
            p_a = ext_if.a;
            p_d = ext_if.din;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        {a_cs, a_oe, a_we} = 3'($urandom);
        a_a = 18'($urandom);
        a_d = 8'($urandom);
    endtask

    typedef struct {
        logic [2:0]  str;
        logic [17:0] a;
        logic [7:0]  d;
        logic [1:0]  boot_csoe;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int w, t, errs, prog_at_rst;
        logic [17:0] ad;
        vecs[0] = '{3'b000, 18'h00000, 8'h00, 2'b01};
        vecs[1] = '{3'b111, 18'h3FFFF, 8'hFF, 2'b01};
        vecs[2] = '{3'b101, 18'h2AAAA, 8'hA5, 2'b01};
        vecs[3] = '{3'b010, 18'h15555, 8'h5A, 2'b01};
        vecs[4] = '{3'b110, 18'h0C000, 8'h01, 2'b01};
        vecs[5] = '{3'b001, 18'h00100, 8'h80, 2'b01};
        w = 0;
`ifdef FLASH_WAKEUP_EN
        w = 1;
`endif
        repeat (3) step();
        check("rst_state0", {u[0].booting, u[0].progress, u[0].ssel, u[0].sck, u[0].mosi, u[0].ext_if.we_b, u[0].ext_if.a, u[0].ext_if.din},
              {6'b101001, BS[0], 8'h00});
        check("rst_state1", {u[1].booting, u[1].progress, u[1].ssel, u[1].sck, u[1].mosi, u[1].ext_if.we_b, u[1].ext_if.a, u[1].ext_if.din},
              {6'b101001, BS[1], 8'h00});
        check("rst_state2", {u[2].booting, u[2].progress, u[2].ssel, u[2].sck, u[2].mosi, u[2].ext_if.we_b, u[2].ext_if.a, u[2].ext_if.din},
              {6'b101001, BS[2], 8'h00});
        reset_b = 1;
        reset_b0 = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            {a_cs, a_oe, a_we} = vecs[i].str;
            a_a = vecs[i].a;
            a_d = vecs[i].d;
            #1;
            check($sformatf("vec_boot%0d", i), {u[0].ext_if.cs_b, u[0].ext_if.oe_b}, vecs[i].boot_csoe);
        end

        t = 0;
        while (u[0].n_prog < 10 && t < 20000) begin
            step();
            t++;
        end
        check("ten_bytes_timeout", t < 20000, 1);
        repeat (8) step();
        prog_at_rst = u[0].n_prog;
        reset_b0 = 0;
        #1;
        check("mid_reset", {u[0].ssel, u[0].booting, u[0].sck, u[0].progress}, 4'b1100);
        repeat (3) step();
        reset_b0 = 1;

        t = 0;
        while ((u[0].booting || u[1].booting || u[2].booting) && t < 60000) begin
            step();
            t++;
        end
        check("boot_timeout", t < 60000, 1);
        repeat (50) step();
        for (int i = 0; i < 6; i++) begin
            step();
            {a_cs, a_oe, a_we} = vecs[i].str;
            a_a = vecs[i].a;
            a_d = vecs[i].d;
            #1;
            check($sformatf("vec_pass%0d", i),
                  {u[0].ext_if.cs_b, u[0].ext_if.oe_b, u[0].ext_if.we_b, u[0].ext_if.a, u[0].ext_if.din},
                  {vecs[i].str, vecs[i].a, vecs[i].d});
        end
        repeat (5) step();

        check("d0_txns", u[0].heads.size(), 2 * (1 + w));
        if (u[0].heads.size() == 2 * (1 + w)) begin
            check("d0_cmd_first", u[0].heads[w], 32'h03000000);
            check("d0_cmd_resent", u[0].heads[2 * w + 1], 32'h03000000);
            check("d0_len", u[0].lens[2 * w + 1], 32 + 8 * 256);
        end
        check("d0_progress", u[0].n_prog - prog_at_rst, 256);
        check("d0_bfall", u[0].n_bfall, 1);
        errs = 0;
        for (int k = 0; k < 256; k++) begin
            ad = 18'h0C000 + 18'(k);
            if (!u[0].mem.exists(ad) || u[0].mem[ad] !== (8'(k) ^ 8'h5A)) errs++;
        end
        check("d0_sram", errs, 0);
        check("d0_sram_extent", u[0].mem.size(), 256);
        check("d0_protocol", {u[0].bad_mux, u[0].bad_we, u[0].bad_spi, u[0].bad_ssel}, 0);

        check("d1_txns", u[1].heads.size(), 1 + w);
        if (u[1].heads.size() == 1 + w) begin
            check("d1_cmd", u[1].heads[w], 32'h03123456);
            check("d1_len", u[1].lens[w], 40);
        end
        check("d1_sck_rises", u[1].n_rise, 40 + 8 * w);
        check("d1_writes", u[1].n_wr, 1);
        check("d1_sram", u[1].mem.exists(18'h00100) ? u[1].mem[18'h00100] : 8'hxx, 8'h0C);
        check("d1_progress", u[1].n_prog, 1);
        check("d1_bfall", u[1].n_bfall, 1);
        check("d1_protocol", {u[1].bad_mux, u[1].bad_we, u[1].bad_spi, u[1].bad_ssel}, 0);

        if (u[2].heads.size() > w) check("d2_cmd", u[2].heads[w], 32'h03FFFFF8);
        else check("d2_txns", u[2].heads.size(), 1 + w);
        errs = 0;
        for (int k = 0; k < 16; k++) begin
            ad = 18'h3FFF0 + 18'(k);
            if (!u[2].mem.exists(ad) || u[2].mem[ad] !== ((8'hF8 + 8'(k)) ^ 8'h5A)) errs++;
        end
        check("d2_sram", errs, 0);
        check("d2_progress", u[2].n_prog, 16);
        check("d2_protocol", {u[2].bad_mux, u[2].bad_we, u[2].bad_spi, u[2].bad_ssel}, 0);
`ifdef FLASH_WAKEUP_EN
        if (u[1].heads.size() >= 2 && u[1].gaps.size() >= 2) begin
            check("wake_cmd", u[1].heads[0], 32'h000000AB);
            check("wake_len", u[1].lens[0], 8);
            check("wake_gap", u[1].gaps[1] >= 4096, 1);
        end else check("wake_txns", u[1].heads.size(), 2);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
